// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a loader write port, and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        ImemWE,
  input  logic [31:0] ImemWAddr,
  input  logic [31:0] ImemWData,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic        MisalignF
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] mem [IMEM_DEPTH];

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, pcd_reg, pcp4_reg, count_reg;
  logic        valid_reg, misalign_reg;

  logic          pc_in_range;
  logic [31:0]   fetched;
  logic [31:0]   pc_plus4;
  logic          waddr_in_range;
  logic          ifid_load;

  // Any address bit at or above the memory span means the PC is out of range.
  assign pc_in_range    = (pc_reg[31:AW+2] == '0);
  assign fetched        = pc_in_range ? mem[pc_reg[AW+1:2]] : NOP_INSTR;
  assign pc_plus4       = pc_reg + 32'd4;
  assign waddr_in_range = (ImemWAddr[31:AW] == '0);
  assign ifid_load      = !FlushD && !StallD;

  always_comb begin
    pc_next = pc_reg;
    if (PCSrcE)
      pc_next = {PCTargetE[31:2], 2'b00};
    else if (!StallF)
      pc_next = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP_INSTR;
      pcd_reg      <= 32'd0;
      pcp4_reg     <= 32'd0;
      valid_reg    <= 1'b0;
      count_reg    <= 32'd0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (PCSrcE && (PCTargetE[1:0] != 2'b00))
        misalign_reg <= 1'b1;

      if (FlushD) begin
        instr_reg <= NOP_INSTR;
        pcd_reg   <= 32'd0;
        pcp4_reg  <= 32'd0;
        valid_reg <= 1'b0;
      end else if (ifid_load) begin
        instr_reg <= fetched;
        pcd_reg   <= pc_reg;
        pcp4_reg  <= pc_plus4;
        valid_reg <= pc_in_range;
      end

      if (ifid_load && pc_in_range)
        count_reg <= count_reg + 32'd1;
    end
  end

  // Memory is never cleared; reset only blocks the loader for that cycle.
  always_ff @(posedge clk) begin
    if (!rst && ImemWE && waddr_in_range)
      mem[ImemWAddr[AW-1:0]] <= ImemWData;
  end

  assign PCF        = pc_reg;
  assign InstrD     = instr_reg;
  assign PCD        = pcd_reg;
  assign PCPlus4D   = pcp4_reg;
  assign ValidD     = valid_reg;
  assign FetchCount = count_reg;
  assign MisalignF  = misalign_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallF, StallD, FlushD, ImemWE;
  logic [31:0] PCTargetE, ImemWAddr, ImemWData;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD, MisalignF;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ImemWE(ImemWE), .ImemWAddr(ImemWAddr), .ImemWData(ImemWData),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchCount(FetchCount), .MisalignF(MisalignF)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; PCSrcE = 0; PCTargetE = 0; StallF = 0; StallD = 0; FlushD = 0;
    ImemWE = 0; ImemWAddr = 0; ImemWData = 0;
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare.
  task automatic tick();
    logic        in_range;
    logic [31:0] word;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0; m_mis = 0;
    end else begin
      in_range = (m_pc < 4 * DEPTH);
      word     = in_range ? m_mem[m_pc / 4] : NOP;
      if (FlushD) begin
        m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!StallD) begin
        m_instr = word; m_pcd = m_pc; m_pcp4 = m_pc + 4; m_valid = in_range;
        if (in_range) m_cnt = m_cnt + 1;
      end
      if (PCSrcE) begin
        m_pc = PCTargetE & 32'hFFFFFFFC;
        if (PCTargetE % 4 != 0) m_mis = 1;
      end else if (!StallF) begin
        m_pc = m_pc + 4;
      end
      if (ImemWE && ImemWAddr < DEPTH) m_mem[ImemWAddr] = ImemWData;
    end
    #1;
    $display("cyc t=%0t rst=%0b src=%0b tgt=%08h sf=%0b sd=%0b fd=%0b we=%0b | PCF=%08h InstrD=%08h PCD=%08h V=%0b FC=%0d MIS=%0b",
             $time, rst, PCSrcE, PCTargetE, StallF, StallD, FlushD, ImemWE,
             PCF, InstrD, PCD, ValidD, FetchCount, MisalignF);
    check("PCF", PCF, m_pc);
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pcp4);
    check("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
    check("FetchCount", FetchCount, m_cnt);
    check("MisalignF", {31'd0, MisalignF}, {31'd0, m_mis});
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic sf);
    idle(); PCSrcE = 1; PCTargetE = tgt; StallF = sf; tick();
  endtask

  logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
  logic [31:0] old5;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    @(negedge clk);
    idle(); rst = 1; tick(); tick();
    check("rst_pc", PCF, 32'h0);
    check("rst_instr", InstrD, NOP);

    // Load the program while fetch and decode are held
    for (int i = 0; i < DEPTH; i++) begin
      idle(); StallF = 1; StallD = 1; ImemWE = 1; ImemWAddr = i;
      ImemWData = (i < 4) ? prog[i] : 32'hA0000000 + i;
      tick();
    end
    // Ignored out-of-range write
    idle(); StallF = 1; StallD = 1; ImemWE = 1; ImemWAddr = DEPTH; ImemWData = 32'hBAD0BAD0; tick();

    idle(); tick();
    check("seq_pc4", PCF, 32'd4);
    check("seq_instr0", InstrD, 32'h00500093);
    check("seq_pcp4", PCPlus4D, 32'd4);
    check("seq_fc1", FetchCount, 32'd1);
    idle(); tick();
    check("seq_pcd4", PCD, 32'd4);

    for (int i = 0; i < 3; i++) begin
      idle(); StallF = 1; StallD = 1; tick();
    end
    check("stall_pc", PCF, 32'd8);
    check("stall_fc", FetchCount, 32'd2);
    idle(); tick();
    check("resume_pcd", PCD, 32'd8);
    check("resume_instr", InstrD, 32'h002081B3);

    idle(); FlushD = 1; StallD = 1; tick();
    check("flush_instr", InstrD, NOP);
    check("flush_valid", {31'd0, ValidD}, 32'd0);
    check("flush_fc", FetchCount, 32'd3);

    redirect(32'h40, 1'b1);
    check("redir_pc", PCF, 32'h40);
    redirect(32'h46, 1'b0);
    check("redir_mis_pc", PCF, 32'h44);
    check("redir_mis", {31'd0, MisalignF}, 32'd1);

    redirect(32'h3C, 1'b0);
    idle(); tick();
    check("edge_valid_last", {31'd0, ValidD}, 32'd1);
    check("edge_instr_last", InstrD, 32'hA000000F);
    idle(); tick();
    check("edge_valid_oob", {31'd0, ValidD}, 32'd0);
    check("edge_instr_oob", InstrD, NOP);

    redirect(32'hFFFFFFFC, 1'b0);
    idle(); tick();
    check("wrap_pc", PCF, 32'h0);

    redirect(32'h14, 1'b0);
    old5 = m_mem[5];
    idle(); StallF = 1; ImemWE = 1; ImemWAddr = 5; ImemWData = 32'hDEADBEEF; tick();
    check("ld_old", InstrD, old5);
    idle(); tick();
    check("ld_new", InstrD, 32'hDEADBEEF);

    // Run to a nonzero count, then reset mid-stream with a colliding loader write
    for (int i = 0; i < 5; i++) begin
      idle(); tick();
    end
    idle(); rst = 1; ImemWE = 1; ImemWAddr = 2; ImemWData = 32'h12345678; tick();
    check("midrst_fc", FetchCount, 32'd0);
    check("midrst_mis", {31'd0, MisalignF}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      rst    = ($urandom_range(0, 99) == 0);
      PCSrcE = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       PCTargetE = 32'hFFFFFFFC - 4 * $urandom_range(0, 2);
        1:       PCTargetE = $urandom();
        default: PCTargetE = $urandom_range(0, 32'h50);
      endcase
      StallF    = ($urandom_range(0, 4) == 0);
      StallD    = ($urandom_range(0, 4) == 0);
      FlushD    = ($urandom_range(0, 6) == 0);
      ImemWE    = ($urandom_range(0, 7) == 0);
      ImemWAddr = $urandom_range(0, 2 * DEPTH - 1);
      ImemWData = $urandom();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
